// File: rtl/lsu_dmem_if.sv
// lsu_dmem_if: LSU <-> data-memory bus.
//   master: LSU execute side (drives store/load requests, observes status).
//   slave : lsu_dmem (accepts requests, returns load data and buffer status).
//   Store request : wr_addr, wr_data, wr_en
//   Load request  : rd_addr, rd_en
//   Load response : rd_data, rd_valid
//   Status        : stall_req, sb_count, ovf_err, misalign_err
interface lsu_dmem_if #(
    parameter int unsigned SB_DEPTH = 4
);
    localparam int unsigned CW = $clog2(SB_DEPTH) + 1;

    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic          wr_en;
    logic [31:0]   rd_addr;
    logic          rd_en;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic          stall_req;
    logic [CW-1:0] sb_count;
    logic          ovf_err;
    logic          misalign_err;

    modport master (
        output wr_addr, wr_data, wr_en, rd_addr, rd_en,
        input  rd_data, rd_valid, stall_req, sb_count, ovf_err, misalign_err
    );

    modport slave (
        input  wr_addr, wr_data, wr_en, rd_addr, rd_en,
        output rd_data, rd_valid, stall_req, sb_count, ovf_err, misalign_err
    );
endinterface

// File: rtl/lsu_dmem.sv
// lsu_dmem: word-addressed data memory fronted by a FIFO store buffer.
// Stores are queued and drained into the array on cycles without a load;
// loads have one-cycle latency and forward from the youngest matching
// buffered store.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - lsu_dmem_if.slave (store/load requests, load response, status)
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses
// (misalign_err, misaligned stores dropped, misaligned loads return 0).
module lsu_dmem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned SB_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    lsu_dmem_if.slave   bus
);
    localparam int unsigned IW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = $clog2(SB_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [31:0]   data;
    } sb_entry_t;

    sb_entry_t     sb [SB_DEPTH];
    logic [31:0]   mem [DEPTH_WORDS];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   rd_data_q;
    logic          rd_valid_q;
    logic          ovf_q;
    logic          mis_q;

    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          wr_mis;
    logic          rd_mis;
    logic          full;
    logic          push;
    logic          drain;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [PW-1:0] slot;
    logic [31:0]   rd_word;
    logic          unused_addr_bits;

    assign wr_idx = bus.wr_addr[IW+1:2];
    assign rd_idx = bus.rd_addr[IW+1:2];

    // Upper address bits alias; low bits only matter with alignment checking.
    assign unused_addr_bits = ^{bus.wr_addr[31:IW+2], bus.wr_addr[1:0],
                                bus.rd_addr[31:IW+2], bus.rd_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign wr_mis = bus.wr_en && (bus.wr_addr[1:0] != 2'b00);
    assign rd_mis = bus.rd_en && (bus.rd_addr[1:0] != 2'b00);
`else
    assign wr_mis = 1'b0;
    assign rd_mis = 1'b0;
`endif

    // A full buffer refuses stores even if a drain frees a slot this cycle.
    assign full  = (count == CW'(SB_DEPTH));
    assign push  = bus.wr_en && !wr_mis && !full;
    assign drain = !bus.rd_en && (count != '0);

    // Youngest-match forwarding: scan oldest to youngest, last hit wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            slot = head + PW'(i);
            if ((CW'(i) < count) && (sb[slot].idx == rd_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb[slot].data;
            end
        end
    end

    assign rd_word = rd_mis  ? 32'h0 :
                     fwd_hit ? fwd_data : mem[rd_idx];

    // Control state, load response and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (drain) begin
                head <= head + PW'(1);
            end
            if (push && !drain) begin
                count <= count + CW'(1);
            end else if (!push && drain) begin
                count <= count - CW'(1);
            end
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= rd_word;
            end
            if (bus.wr_en && !wr_mis && full) begin
                ovf_q <= 1'b1;
            end
            if (wr_mis || rd_mis) begin
                mis_q <= 1'b1;
            end
        end
    end

    // Buffer payload storage; not reset, validity comes from count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            sb[tail] <= '{idx: wr_idx, data: bus.wr_data};
        end
    end

    // Data array; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && drain) begin
            mem[sb[head].idx] <= sb[head].data;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.stall_req    = full;
    assign bus.sb_count     = count;
    assign bus.ovf_err      = ovf_q;
    assign bus.misalign_err = mis_q;
endmodule
